alu_serial_seq: RTL and testbench
=================================

ALU_SERIAL_SEQ -- requirements
Module: alu_serial_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  3  ALU control: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-006 SHALL have port a  input  WIDTH  operand A, sampled with start.
REQ-007 SHALL have port b  input  WIDTH  operand B, sampled with start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress (RUN state).
REQ-009 SHALL have port done  output  1  one-cycle pulse marking result/flags valid.
REQ-010 SHALL have port result  output  WIDTH  operation result, held until next accepted start.
REQ-011 SHALL have port zero  output  1  high when result equals 0; held with result.
REQ-012 SHALL have port overflow  output  1  signed overflow for ADD/SUB/SLT subtraction; 0 for AND/OR.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE when bit counter reaches WIDTH-1, DONE->IDLE unconditionally.
REQ-014 SHALL, on accepting start in IDLE, latch a, b, op, clear the bit counter, and preset carry to 1 for SUB/SLT, 0 otherwise.
REQ-015 SHALL process exactly one bit per RUN cycle, LSB first: per bit compute a&b', a|b', full-add sum of a, b', carry, and select by op (b' = ~b for SUB/SLT, else b).
REQ-016 SHALL register carry-out of each bit as carry-in of the next.
REQ-017 SHALL, for SLT, force result bits WIDTH-1..1 to 0 and set bit 0 to (sum MSB XOR overflow) of a-b.
REQ-018 SHALL compute overflow as carry-in XOR carry-out of the MSB bit for ADD/SUB/SLT.
REQ-019 SHALL assert done exactly WIDTH+1 rising edges after the edge sampling start (33 for WIDTH=32); busy high for exactly WIDTH cycles.
REQ-020 SHALL ignore start while in RUN or DONE; operands latched at acceptance stay unchanged.
REQ-021 SHALL accept start in the cycle immediately after DONE (back-to-back throughput WIDTH+2 cycles).
REQ-022 SHALL treat undefined op codes as producing result 0, overflow 0, with normal timing and done pulse.
REQ-023 SHALL keep result, zero, overflow stable from done until the next accepted start updates them.

Reset
REQ-024 SHALL, when rst is high at a clock edge, enter IDLE and clear busy, done, result, overflow to 0 and set zero to 1, regardless of state.
REQ-025 SHALL abandon any in-flight operation on reset with no done pulse; rst takes priority over start in the same cycle.

Structure
REQ-026 SHALL take op codes, WIDTH default, and FSM state encoding from shared package alu_pkg.
REQ-027 SHALL instantiate one sub-module alu_bit_slice (one-bit AND/OR/full-add plus 4:1 select, combinational) for the per-bit datapath.
REQ-028 SHALL keep sequencing (FSM, counter, shift registers, carry flop) in alu_serial_seq only.

Verification
REQ-029 ADD a=5, b=3, start 1 cycle -> done at edge 33, result=8, zero=0, overflow=0, busy high 32 cycles.
REQ-030 SUB a=3, b=5 -> result=0xFFFFFFFE, overflow=0; SUB a=7, b=7 -> result=0, zero=1.
REQ-031 SLT a=0xFFFFFFFF (-1), b=1 -> result=1; SLT a=0x7FFFFFFF, b=0x80000000 -> result=0, overflow=1.
REQ-032 ADD a=0x7FFFFFFF, b=1 -> result=0x80000000, overflow=1; AND 0xF0F0F0F0,0xFF00FF00 -> 0xF000F000.
REQ-033 Start pulsed again with new operands at cycle 10 of RUN -> ignored, first result unaffected; start on cycle after done -> accepted.
REQ-034 rst asserted at cycle 15 of RUN -> next cycle IDLE, busy=0, result=0, zero=1, no done pulse.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, FSM encoding and per-op decode helpers
// for the bit-serial ALU.
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      SEL_AND  = 2'b00,
      SEL_OR   = 2'b01,
      SEL_SUM  = 2'b10,
      SEL_ZERO = 2'b11
   } sel_e;

   function automatic sel_e op_sel(input logic [2:0] op);
      sel_e s;
      unique case (op)
         OP_AND:                 s = SEL_AND;
         OP_OR:                  s = SEL_OR;
         OP_ADD, OP_SUB, OP_SLT: s = SEL_SUM;
         default:                s = SEL_ZERO;
      endcase
      return s;
   endfunction

   // Subtraction: invert b and preset carry to 1
   function automatic logic op_is_sub(input logic [2:0] op);
      return (op == OP_SUB) || (op == OP_SLT);
   endfunction

   function automatic logic op_is_arith(input logic [2:0] op);
      return (op == OP_ADD) || op_is_sub(op);
   endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: AND, OR and full-add, picked by a
// 4:1 select. Purely combinational.
module alu_bit_slice
   import alu_pkg::*;
(
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   input  sel_e sel_i,
   output logic r_o,
   output logic cout_o
);

   logic and_w;
   logic or_w;
   logic sum_w;

   assign and_w  = a_i & b_i;
   assign or_w   = a_i | b_i;
   assign sum_w  = a_i ^ b_i ^ cin_i;
   assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

   always_comb begin
      r_o = 1'b0;
      unique case (sel_i)
         SEL_AND:  r_o = and_w;
         SEL_OR:   r_o = or_w;
         SEL_SUM:  r_o = sum_w;
         default:  r_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU: one bit per RUN cycle, LSB first, with
// result/flags committed in DONE and a one-cycle done pulse.
module alu_serial_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e state_q, state_d;

   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [2:0]       op_q;
   logic             carry_q;
   logic [WIDTH-1:0] sh_q;
   logic             ovf_run_q;
   logic [WIDTH-1:0] result_q;
   logic             zero_q;
   logic             ovf_q;
   logic             done_q;

   logic             last_w;
   logic             a_bit;
   logic             b_bit;
   logic             r_bit;
   logic             cout_w;
   logic [WIDTH-1:0] res_fin;
   logic             ovf_fin;

   assign last_w = (cnt_q == LAST);
   assign a_bit  = a_q[cnt_q];
   assign b_bit  = b_q[cnt_q] ^ op_is_sub(op_q);

   alu_bit_slice u_slice (
      .a_i    (a_bit),
      .b_i    (b_bit),
      .cin_i  (carry_q),
      .sel_i  (op_sel(op_q)),
      .r_o    (r_bit),
      .cout_o (cout_w)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (last_w) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == S_RUN);
   end

   // SLT keeps only the sign of a-b, corrected for overflow
   always_comb begin
      res_fin = sh_q;
      ovf_fin = op_is_arith(op_q) & ovf_run_q;
      if (op_q == OP_SLT) begin
         res_fin    = '0;
         res_fin[0] = sh_q[WIDTH-1] ^ ovf_run_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= OP_AND;
         carry_q   <= 1'b0;
         sh_q      <= '0;
         ovf_run_q <= 1'b0;
         result_q  <= '0;
         zero_q    <= 1'b1;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  op_q    <= op;
                  cnt_q   <= '0;
                  carry_q <= op_is_sub(op);
               end
            end
            S_RUN: begin
               sh_q    <= {r_bit, sh_q[WIDTH-1:1]};
               carry_q <= cout_w;
               cnt_q   <= cnt_q + 1'b1;
               if (last_w) ovf_run_q <= carry_q ^ cout_w;
            end
            S_DONE: begin
               result_q <= res_fin;
               zero_q   <= (res_fin == '0);
               ovf_q    <= ovf_fin;
               done_q   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign done     = done_q;
   assign result   = result_q;
   assign zero     = zero_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed self-checking bench for alu_serial_seq
// (WIDTH=32), one task per scenario.
module tb_alu_serial_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        zero;
   logic        overflow;

   int checks;
   int failures;

   alu_serial_seq #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .zero     (zero),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse start for one cycle, then wait (bounded) for done.
   // edges = rising edges from the start edge to done (0 = timeout).
   task automatic do_op(input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, output int edges,
                        output int busy_cnt);
      edges = 0;
      busy_cnt = 0;
      @(negedge clk);
      start = 1'b1;
      op = o;
      a = x;
      b = y;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (busy) busy_cnt++;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk);
         #1;
         if (busy) busy_cnt++;
         if (done) begin
            edges = n;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      start = 1'b0;
      op = 3'b000;
      a = '0;
      b = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctl busy=%b done=%b want 0 0", busy, done);
      end
      checks++;
      if (result !== 32'h0 || zero !== 1'b1 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags res=%h z=%b v=%b want 0 1 0",
                  result, zero, overflow);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add;
      int e, bc;
      do_op(3'b010, 32'd5, 32'd3, e, bc);
      checks++;
      if (e !== 33) begin
         failures++;
         $display("FAIL add_latency edges=%0d want 33", e);
      end
      checks++;
      if (bc !== 32) begin
         failures++;
         $display("FAIL add_busy cycles=%0d want 32", bc);
      end
      checks++;
      if (result !== 32'd8 || zero !== 1'b0 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL add_5_3 res=%h z=%b v=%b want 00000008 0 0",
                  result, zero, overflow);
      end
      do_op(3'b010, 32'h7FFF_FFFF, 32'd1, e, bc);
      checks++;
      if (result !== 32'h8000_0000 || overflow !== 1'b1) begin
         failures++;
         $display("FAIL add_ovf res=%h v=%b want 80000000 1",
                  result, overflow);
      end
   endtask

   task automatic test_sub;
      int e, bc;
      do_op(3'b110, 32'd3, 32'd5, e, bc);
      checks++;
      if (result !== 32'hFFFF_FFFE || overflow !== 1'b0 || zero !== 1'b0) begin
         failures++;
         $display("FAIL sub_3_5 res=%h v=%b z=%b want fffffffe 0 0",
                  result, overflow, zero);
      end
      do_op(3'b110, 32'd7, 32'd7, e, bc);
      checks++;
      if (result !== 32'h0 || zero !== 1'b1 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL sub_7_7 res=%h z=%b v=%b want 0 1 0",
                  result, zero, overflow);
      end
   endtask

   task automatic test_slt;
      int e, bc;
      do_op(3'b111, 32'hFFFF_FFFF, 32'd1, e, bc);
      checks++;
      if (result !== 32'd1 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL slt_neg res=%h v=%b want 00000001 0",
                  result, overflow);
      end
      do_op(3'b111, 32'h7FFF_FFFF, 32'h8000_0000, e, bc);
      checks++;
      if (result !== 32'd0 || overflow !== 1'b1 || zero !== 1'b1) begin
         failures++;
         $display("FAIL slt_ovf res=%h v=%b z=%b want 0 1 1",
                  result, overflow, zero);
      end
   endtask

   task automatic test_logic;
      int e, bc;
      do_op(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, e, bc);
      checks++;
      if (result !== 32'hF000_F000 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL and res=%h v=%b want f000f000 0", result, overflow);
      end
      do_op(3'b001, 32'hF0F0_F0F0, 32'h0F0F_0000, e, bc);
      checks++;
      if (result !== 32'hFFFF_F0F0 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL or res=%h v=%b want fffff0f0 0", result, overflow);
      end
      do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e, bc);
      checks++;
      if (e !== 33 || result !== 32'h0 || overflow !== 1'b0 || zero !== 1'b1) begin
         failures++;
         $display("FAIL undef_op edges=%0d res=%h v=%b z=%b want 33 0 0 1",
                  e, result, overflow, zero);
      end
   endtask

   task automatic test_ignore_start;
      int e;
      e = 0;
      @(negedge clk);
      start = 1'b1;
      op = 3'b010;
      a = 32'd10;
      b = 32'd20;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      op = 3'b110;
      a = 32'd100;
      b = 32'd200;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int n = 11; n <= 60; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            e = n;
            break;
         end
      end
      checks++;
      if (e !== 33 || result !== 32'd30 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL ignore_start edges=%0d res=%h v=%b want 33 0000001e 0",
                  e, result, overflow);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || result !== 32'd30) begin
         failures++;
         $display("FAIL done_pulse done=%b res=%h want 0 0000001e",
                  done, result);
      end
   endtask

   task automatic test_back_to_back;
      int e, bc;
      do_op(3'b010, 32'd1, 32'd2, e, bc);
      do_op(3'b010, 32'd40, 32'd2, e, bc);
      checks++;
      if (e !== 33 || bc !== 32 || result !== 32'd42) begin
         failures++;
         $display("FAIL back_to_back edges=%0d busy=%0d res=%h want 33 32 0000002a",
                  e, bc, result);
      end
   endtask

   task automatic test_reset_mid_run;
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      start = 1'b1;
      op = 3'b010;
      a = 32'd9;
      b = 32'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || result !== 32'h0 || zero !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_run busy=%b res=%h z=%b done=%b want 0 0 1 0",
                  busy, result, zero, done);
      end
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk);
         #1;
         if (done || busy) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL reset_no_done activity=%b want 0", seen);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_add();
      test_sub();
      test_slt();
      test_logic();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
